// File: rtl/ram_mover_pkg.sv
// Shared types for the RAM block mover: FSM state encoding and command mode constants.
package ram_mover_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/ram_mover_addr_gen.sv
// Word offset counter for the block mover; produces src+i, dst+i (modulo depth) and the last-word flag.
module ram_mover_addr_gen #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last
);

    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] i_d;

    always_comb begin
        i_d = i_q;
        if (clr) begin
            i_d = '0;
        end else if (inc) begin
            i_d = i_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
        end else begin
            i_q <= i_d;
        end
    end

    // Sums truncate to ADDR_W bits, so addresses wrap around the memory silently.
    assign src_addr = src_base + i_q;
    assign dst_addr = dst_base + i_q;
    assign last     = ({1'b0, i_q} == (len - (ADDR_W + 1)'(1)));

endmodule

// File: rtl/ram_block_mover.sv
// Block fill / ascending block copy engine driving a word-addressed RAM (in, load, address, out).
// Optional write checksum output enabled by defining RAM_BLOCK_MOVER_CSUM_EN.
module ram_block_mover
    import ram_mover_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output state_t            state_dbg,
    input  logic [DATA_W-1:0] mem_out
`ifdef RAM_BLOCK_MOVER_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              accept;
    logic              clr_i;
    logic              inc_i;
    logic              last;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;

    ram_mover_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (reset),
        .clr     (clr_i),
        .inc     (inc_i),
        .src_base(src_q),
        .dst_base(dst_q),
        .len     (len_q),
        .src_addr(src_cur),
        .dst_addr(dst_cur),
        .last    (last)
    );

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        hold_d  = hold_q;
        clr_i   = 1'b0;
        inc_i   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_value;
                    clr_i  = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (mode == MODE_COPY) begin
                        state_d = RD;
                    end else begin
                        state_d = FILL;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                inc_i = 1'b1;
                if (last) state_d = DONE;
            end
            RD: begin
                hold_d  = mem_out;
                state_d = WR;
            end
            WR: begin
                inc_i   = 1'b1;
                state_d = last ? DONE : RD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on start/mode/len directly.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_in      = '0;
        mem_load    = 1'b0;
        mem_address = '0;
        case (state_q)
            FILL: begin
                busy        = 1'b1;
                mem_address = dst_cur;
                mem_in      = fill_q;
                mem_load    = 1'b1;
            end
            RD: begin
                busy        = 1'b1;
                mem_address = src_cur;
            end
            WR: begin
                busy        = 1'b1;
                mem_address = dst_cur;
                mem_in      = hold_q;
                mem_load    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

`ifdef RAM_BLOCK_MOVER_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = '0;
        end else if (mem_load) begin
            csum_d = csum_q + mem_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule
